// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer and its next-PC selector.
package pc_sequencer_pkg;

    localparam int unsigned PcWidth = 32;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StWait   = 3'd2,
        StIssue  = 3'd3,
        StExec   = 3'd4,
        StUpdate = 3'd5,
        StHalt   = 3'd6,
        StFault  = 3'd7
    } state_e;

    localparam logic [1:0] FaultNone       = 2'd0;
    localparam logic [1:0] FaultTimeout    = 2'd1;
    localparam logic [1:0] FaultMisaligned = 2'd2;

endpackage

// File: rtl/pc_next_select.sv
// Next-PC priority mux (jump > branch > sequential) with target alignment check.
module pc_next_select
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PcStep = 4
) (
    input  logic [PcWidth-1:0] pc_i,
    input  logic               jump_i,
    input  logic [PcWidth-1:0] jump_target_i,
    input  logic               branch_taken_i,
    input  logic [PcWidth-1:0] branch_target_i,
    output logic [PcWidth-1:0] next_pc_o,
    output logic               misaligned_o
);

    always_comb begin
        // Sequential addition wraps modulo 2^32.
        next_pc_o = pc_i + PcStep;
        if (jump_i) begin
            next_pc_o = jump_target_i;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i;
        end
        misaligned_o = |next_pc_o[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/issue/execute/update controller owning the architectural PC.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_current,
    output logic        pc_we,
    output logic [31:0] retired,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [7:0] TimeoutLimit = 8'(FETCH_TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        halt_latch_q, halt_latch_d;
    logic        single_step_q, single_step_d;
    logic [31:0] sel_pc;
    logic        sel_misaligned;

    pc_next_select #(
        .PcStep (PC_STEP)
    ) u_next_select (
        .pc_i            (pc_q),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .next_pc_o       (sel_pc),
        .misaligned_o    (sel_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        wait_cnt_d    = wait_cnt_q;
        fault_code_d  = fault_code_q;
        halt_latch_d  = halt_latch_q | halt_req;
        single_step_d = single_step_q;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        pc_we         = 1'b0;

        case (state_q)
            StIdle: begin
                if (run || step) begin
                    state_d       = StFetch;
                    single_step_d = step;
                end
            end
            StFetch: begin
                imem_req   = 1'b1;
                wait_cnt_d = 8'd0;
                state_d    = StWait;
            end
            StWait: begin
                // An ack always beats a timeout landing in the same cycle.
                if (imem_ack) begin
                    instr_d = imem_instr;
                    state_d = StIssue;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TimeoutLimit) begin
                        state_d      = StFault;
                        fault_code_d = FaultTimeout;
                    end
                end
            end
            StIssue: begin
                instr_valid = 1'b1;
                state_d     = StExec;
            end
            StExec: begin
                if (exec_done) begin
                    if (sel_misaligned) begin
                        state_d      = StFault;
                        fault_code_d = FaultMisaligned;
                    end else begin
                        next_pc_d = sel_pc;
                        state_d   = StUpdate;
                    end
                end
            end
            StUpdate: begin
                pc_we     = 1'b1;
                pc_d      = next_pc_q;
                retired_d = retired_q + 32'd1;
                if (halt_latch_q || halt_req) begin
                    state_d = StHalt;
                end else if (single_step_q || !run) begin
                    state_d       = StIdle;
                    single_step_d = 1'b0;
                end else begin
                    state_d = StFetch;
                end
            end
            StHalt, StFault: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_VECTOR;
            next_pc_q     <= RESET_VECTOR;
            instr_q       <= 32'd0;
            retired_q     <= 32'd0;
            wait_cnt_q    <= 8'd0;
            fault_code_q  <= FaultNone;
            halt_latch_q  <= 1'b0;
            single_step_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_code_q  <= fault_code_d;
            halt_latch_q  <= halt_latch_d;
            single_step_q <= single_step_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc_current = pc_q;
    assign instr      = instr_q;
    assign retired    = retired_q;
    assign state      = state_q;
    assign halted     = (state_q == StHalt);
    assign fault      = (state_q == StFault);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an architectural PC/retire model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_instr = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = 32'd0, jump_target = 32'd0;
    logic [31:0] pc_current, retired;
    logic        pc_we, halted, fault;
    logic [2:0]  state;
    logic [1:0]  fault_code;

    int passed = 0;
    int total = 0;
    int n_req = 0, n_we = 0, cyc = 0, last_we_cyc = 0, we_gap = 0;

    pc_sequencer #(
        .RESET_VECTOR  (RV),
        .PC_STEP       (4),
        .FETCH_TIMEOUT (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .step          (step),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_instr    (imem_instr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_current    (pc_current),
        .pc_we         (pc_we),
        .retired       (retired),
        .state         (state),
        .halted        (halted),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1;
        cyc++;
        if (imem_req) n_req++;
        if (pc_we) begin
            we_gap      = cyc - last_we_cyc;
            last_we_cyc = cyc;
            n_we++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic j,
                                             input logic [31:0] jt, input logic b,
                                             input logic [31:0] bt);
        if (j) return jt;
        if (b) return bt;
        return pc + 32'd4;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        imem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Plays memory and execute unit for one instruction; returns what it observed.
    task automatic drive_instr(input int ack_dly, input int exec_dly, input logic hreq,
                               input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt, input logic [31:0] word,
                               output logic got_req, output logic [31:0] addr,
                               output logic [31:0] issued, output logic iv_seen,
                               output logic we_seen);
        got_req = 1'b0; addr = '0; issued = '0; iv_seen = 1'b0; we_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!got_req) return;
        addr       = imem_addr;
        imem_instr = word;
        @(negedge clock);
        repeat (ack_dly) @(negedge clock);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        iv_seen  = instr_valid;
        issued   = instr;
        @(negedge clock);
        halt_req = hreq;
        repeat (exec_dly) begin
            @(negedge clock);
            halt_req = 1'b0;
        end
        exec_done = 1'b1; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        @(negedge clock);
        halt_req = 1'b0; exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = $urandom; branch_target = $urandom;
        we_seen = pc_we;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state);
        else passed++;
        total++; if (pc_current !== RV) $display("FAIL reset_pc: got %h want %h", pc_current, RV);
        else passed++;
        total++;
        if ({instr, retired} !== 64'd0) $display("FAIL reset_regs: got %h %h want 0 0", instr, retired);
        else passed++;
        total++;
        if ({imem_req, instr_valid, pc_we, halted, fault, fault_code} !== 7'd0)
            $display("FAIL reset_strobes: got %b want 0", {imem_req, instr_valid, pc_we, halted, fault, fault_code});
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] m_pc, word, addr, issued;
        logic gr, iv, we;
        do_reset();
        run = 1'b1; m_pc = RV;
        for (int i = 0; i < 3; i++) begin
            word = $urandom;
            drive_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, word, gr, addr, issued, iv, we);
            total++; if (!gr || addr !== m_pc) $display("FAIL seq_addr: got %h want %h", addr, m_pc);
            else passed++;
            total++; if (!iv || issued !== word) $display("FAIL seq_instr: got %h want %h", issued, word);
            else passed++;
            m_pc = m_pc + 32'd4;
            total++; if (!we || pc_current !== m_pc) $display("FAIL seq_pc: got %h want %h", pc_current, m_pc);
            else passed++;
            if (i > 0) begin
                total++; if (we_gap !== 5) $display("FAIL seq_latency: got %0d want 5", we_gap);
                else passed++;
            end
        end
        total++; if (retired !== 32'd3) $display("FAIL seq_retired: got %0d want 3", retired);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] m_pc, exp_pc, word, jt, bt, addr, issued;
        logic j, b, gr, iv, we;
        int m_ret;
        do_reset();
        run = 1'b1; m_pc = RV; m_ret = 0;
        for (int i = 0; i < 24; i++) begin
            word = $urandom;
            j  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 2) == 0);
            jt = $urandom & 32'hFFFF_FFFC;
            bt = $urandom & 32'hFFFF_FFFC;
            drive_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                        j, jt, b, bt, word, gr, addr, issued, iv, we);
            exp_pc = ref_next(m_pc, j, jt, b, bt);
            m_ret++;
            total++; if (!gr || addr !== m_pc) $display("FAIL rand_addr: got %h want %h", addr, m_pc);
            else passed++;
            total++; if (!iv || issued !== word) $display("FAIL rand_instr: got %h want %h", issued, word);
            else passed++;
            total++; if (!we || pc_current !== exp_pc) $display("FAIL rand_pc: got %h want %h", pc_current, exp_pc);
            else passed++;
            total++; if (retired !== 32'(m_ret)) $display("FAIL rand_retired: got %0d want %0d", retired, m_ret);
            else passed++;
            m_pc = exp_pc;
        end
    endtask

    task automatic test_priority();
        logic [31:0] addr, issued;
        logic gr, iv, we;
        do_reset();
        run = 1'b1;
        drive_instr(0, 0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        total++; if (pc_current !== 32'h40) $display("FAIL prio_setup: got %h want 40", pc_current);
        else passed++;
        drive_instr(0, 1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h80, $urandom, gr, addr, issued, iv, we);
        total++; if (pc_current !== 32'h100) $display("FAIL prio_jump: got %h want 100", pc_current);
        else passed++;
        // Misaligned branch target is irrelevant when jump wins.
        drive_instr(0, 0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h82, $urandom, gr, addr, issued, iv, we);
        total++; if (fault || pc_current !== 32'h200) $display("FAIL prio_jump_mask: got %h f%b want 200 f0", pc_current, fault);
        else passed++;
        drive_instr(0, 0, 1'b0, 1'b0, 32'h300, 1'b1, 32'h80, $urandom, gr, addr, issued, iv, we);
        total++; if (pc_current !== 32'h80) $display("FAIL prio_branch: got %h want 80", pc_current);
        else passed++;
    endtask

    task automatic test_step();
        logic [31:0] addr, issued;
        logic gr, iv, we;
        int r0, w0;
        do_reset();
        r0 = n_req; w0 = n_we;
        repeat (5) @(negedge clock);
        total++; if (state !== 3'd0 || n_req !== r0) $display("FAIL step_idle: got st%0d req%0d want st0 req%0d", state, n_req, r0);
        else passed++;
        for (int k = 1; k <= 2; k++) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            drive_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
            repeat (5) @(negedge clock);
            total++; if (state !== 3'd0) $display("FAIL step_return_idle: got %0d want 0", state);
            else passed++;
            total++;
            if (n_req !== r0 + k || n_we !== w0 + k)
                $display("FAIL step_count: got req%0d we%0d want req%0d we%0d", n_req - r0, n_we - w0, k, k);
            else passed++;
            total++; if (pc_current !== RV + 32'(4 * k)) $display("FAIL step_pc: got %h want %h", pc_current, RV + 32'(4 * k));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] addr, issued;
        logic gr, iv, we;
        int r;
        do_reset();
        run = 1'b1;
        // Ack in the very cycle the counter reaches the limit still completes the fetch.
        drive_instr(3, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        total++; if (fault || !we || pc_current !== RV + 32'd4) $display("FAIL timeout_ack_wins: got %h f%b want %h f0", pc_current, fault, RV + 32'd4);
        else passed++;
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clock);
        total++; if (!imem_req) $display("FAIL timeout_fetch: got req 0 want 1");
        else passed++;
        repeat (4) @(negedge clock);
        total++; if (state !== 3'd2) $display("FAIL timeout_still_wait: got %0d want 2", state);
        else passed++;
        @(negedge clock);
        total++; if (!fault || fault_code !== 2'd1) $display("FAIL timeout_fault: got f%b c%0d want f1 c1", fault, fault_code);
        else passed++;
        total++; if (pc_current !== RV + 32'd4) $display("FAIL timeout_pc: got %h want %h", pc_current, RV + 32'd4);
        else passed++;
        r = n_req;
        repeat (5) @(negedge clock);
        total++; if (n_req !== r || !fault) $display("FAIL timeout_terminal: got req+%0d f%b want req+0 f1", n_req - r, fault);
        else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] addr, issued;
        logic gr, iv, we;
        do_reset();
        run = 1'b1;
        drive_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h102, $urandom, gr, addr, issued, iv, we);
        total++; if (we) $display("FAIL misalign_no_we: got 1 want 0");
        else passed++;
        total++; if (!fault || fault_code !== 2'd2) $display("FAIL misalign_fault: got f%b c%0d want f1 c2", fault, fault_code);
        else passed++;
        total++; if (pc_current !== RV || retired !== 32'd0) $display("FAIL misalign_pc: got %h r%0d want %h r0", pc_current, retired, RV);
        else passed++;
    endtask

    task automatic test_halt();
        logic [31:0] addr, issued;
        logic gr, iv, we;
        int r;
        do_reset();
        run = 1'b1;
        drive_instr(0, 2, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        total++; if (!we || retired !== 32'd1) $display("FAIL halt_retires: got we%b r%0d want we1 r1", we, retired);
        else passed++;
        total++; if (!halted || state !== 3'd6) $display("FAIL halt_state: got h%b st%0d want h1 st6", halted, state);
        else passed++;
        r = n_req;
        repeat (8) @(negedge clock);
        total++; if (n_req !== r) $display("FAIL halt_no_fetch: got req+%0d want req+0", n_req - r);
        else passed++;
        do_reset();
        total++; if (pc_current !== RV || halted) $display("FAIL halt_reset: got %h h%b want %h h0", pc_current, halted, RV);
        else passed++;
        // A request captured while idle is remembered until the next boundary.
        halt_req = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        repeat (3) @(negedge clock);
        run = 1'b1;
        drive_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        total++; if (!halted || pc_current !== RV + 32'd4) $display("FAIL halt_sticky: got h%b %h want h1 %h", halted, pc_current, RV + 32'd4);
        else passed++;
    endtask

    task automatic test_wrap_and_reset_ack();
        logic [31:0] addr, issued, word;
        logic gr, iv, we;
        do_reset();
        run = 1'b1;
        drive_instr(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        drive_instr(1, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, gr, addr, issued, iv, we);
        total++; if (addr !== 32'hFFFF_FFFC || pc_current !== 32'd0) $display("FAIL wrap_pc: got a%h %h want aFFFFFFFC 0", addr, pc_current);
        else passed++;
        word = 32'hDEAD_BEEF;
        drive_instr(0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, word, gr, addr, issued, iv, we);
        total++; if (instr !== word) $display("FAIL rstack_setup: got %h want %h", instr, word);
        else passed++;
        @(negedge clock);
        imem_ack = 1'b1; imem_instr = 32'h1234_5678; reset = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        total++; if (state !== 3'd0 || instr !== 32'd0) $display("FAIL rstack_abort: got st%0d %h want st0 0", state, instr);
        else passed++;
        total++; if (pc_current !== RV || retired !== 32'd0) $display("FAIL rstack_pc: got %h r%0d want %h r0", pc_current, retired, RV);
        else passed++;
        reset = 1'b0; run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_step();
        test_timeout();
        test_misaligned();
        test_halt();
        test_wrap_and_reset_ack();
        test_random();
        run = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
